// File: rtl/core_exec_seq.sv
// core_exec_seq: execute-stage sequencer for the shared ALU/shifter; shifts iterate SHAMT_STEP bits per cycle.
// Build macro EXEC_BYPASS_EN: accept the next op in DONE on the same edge the result is taken.
module core_exec_seq #(
    parameter int SHAMT_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [2:0]  in_imm_type,
    input  logic        in_use_imm,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    output logic [31:0] imm_instr,
    output logic [2:0]  imm_type,
    input  logic [31:0] imm_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        busy
);

    // state | meaning
    // IDLE  | waiting for an op from the decoder
    // LOAD  | parser output valid; pick operand B, run ALU or arm the shifter
    // SHIFT | iterative shift, up to SHAMT_STEP bits per cycle
    // DONE  | result presented until writeback takes it
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [2:0] IMM_Z  = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;

    state_e      r_state;
    state_e      w_state_nxt;
    logic [31:0] r_instr;
    logic [2:0]  r_imm_type;
    logic        r_use_imm;
    logic [2:0]  r_op;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [31:0] r_acc;
    logic [4:0]  r_cnt;
    logic [31:0] r_result;

    logic [31:0] w_b;
    logic        w_is_shift;
    logic        w_last;
    logic [5:0]  w_step;
    logic [31:0] w_shifted;
    logic [31:0] w_alu;
    logic        w_bypass;
    logic        w_accept;

    assign w_b        = r_use_imm ? imm_val : r_rs2;
    assign w_is_shift = (r_op >= OP_SLL);
    assign w_last     = (int'(r_cnt) <= SHAMT_STEP);
    assign w_step     = w_last ? {1'b0, r_cnt} : 6'(SHAMT_STEP);

`ifdef EXEC_BYPASS_EN
    assign w_bypass = (r_state == S_DONE) && out_ready;
`else
    assign w_bypass = 1'b0;
`endif

    always_comb begin
        w_shifted = r_acc;
        case (r_op)
            OP_SLL:  w_shifted = r_acc << w_step;
            OP_SRL:  w_shifted = r_acc >> w_step;
            default: w_shifted = 32'($signed(r_acc) >>> w_step);
        endcase
    end

    always_comb begin
        w_alu = r_rs1;
        case (r_op)
            OP_ADD:  w_alu = r_rs1 + w_b;
            OP_SUB:  w_alu = r_rs1 - w_b;
            OP_AND:  w_alu = r_rs1 & w_b;
            OP_OR:   w_alu = r_rs1 | w_b;
            OP_XOR:  w_alu = r_rs1 ^ w_b;
            default: w_alu = r_rs1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = !flush && ((r_state == S_IDLE) || w_bypass);
        w_accept    = in_valid && in_ready;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept) w_state_nxt = S_LOAD;
                S_LOAD:  w_state_nxt = (w_is_shift && (w_b[4:0] != 5'd0)) ? S_SHIFT : S_DONE;
                S_SHIFT: if (w_last) w_state_nxt = S_DONE;
                S_DONE:  if (out_ready) w_state_nxt = w_accept ? S_LOAD : S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr    <= 32'd0;
            r_imm_type <= IMM_Z;
            r_use_imm  <= 1'b0;
            r_op       <= OP_ADD;
            r_rs1      <= 32'd0;
            r_rs2      <= 32'd0;
            r_acc      <= 32'd0;
            r_cnt      <= 5'd0;
            r_result   <= 32'd0;
        end else begin
            if (w_accept) begin
                r_instr    <= in_instr;
                r_imm_type <= in_imm_type;
                r_use_imm  <= in_use_imm;
                r_op       <= in_op;
                r_rs1      <= in_rs1;
                r_rs2      <= in_rs2;
            end
            if (!flush) begin
                case (r_state)
                    S_LOAD: begin
                        r_acc <= r_rs1;
                        r_cnt <= w_b[4:0];
                        if (!w_is_shift) begin
                            r_result <= w_alu;
                        end else if (w_b[4:0] == 5'd0) begin
                            r_result <= r_rs1;
                        end
                    end
                    S_SHIFT: begin
                        // on the last step w_step equals r_cnt, so the counter lands on zero
                        r_acc <= w_shifted;
                        r_cnt <= r_cnt - w_step[4:0];
                        if (w_last) begin
                            r_result <= w_shifted;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign imm_instr  = r_instr;
    assign imm_type   = r_imm_type;
    assign out_result = r_result;
    assign out_valid  = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);

endmodule
